// File: rtl/bitwise_operand_stage.sv
// rtl/bitwise_operand_stage.sv - operand fetch with writeback forwarding feeding the bitwise logic unit
module bitwise_operand_stage #(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op_sel,
    input  logic                  in_a_sel,
    input  logic [1:0]            in_b_sel,
    input  logic                  in_use_imm,
    input  logic [7:0]            in_imm,
    input  logic [REG_ADDR_W-1:0] in_raddr,
    input  logic                  in_dest_acc,
    output logic                  rf_re,
    output logic [REG_ADDR_W-1:0] rf_raddr,
    input  logic [7:0]            rf_rdata,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [7:0]            wb_data,
    input  logic [7:0]            acc,
    input  logic                  acc_we,
    input  logic [7:0]            acc_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            a,
    output logic [7:0]            b,
    output logic [1:0]            op_sel,
    output logic                  a_sel,
    output logic [1:0]            b_sel,
    output logic                  out_dest_acc,
    output logic [REG_ADDR_W-1:0] out_waddr
);

    typedef struct packed {
        logic [7:0]            a;
        logic [7:0]            b;
        logic [1:0]            op_sel;
        logic                  a_sel;
        logic [1:0]            b_sel;
        logic                  dest_acc;
        logic [REG_ADDR_W-1:0] waddr;
    } entry_t;

    logic                  p_valid;
    logic [1:0]            p_op_sel;
    logic                  p_a_sel;
    logic [1:0]            p_b_sel;
    logic                  p_use_imm;
    logic [7:0]            p_imm;
    logic [REG_ADDR_W-1:0] p_raddr;
    logic                  p_dest_acc;

    logic                  h_we;
    logic [REG_ADDR_W-1:0] h_addr;
    logic [7:0]            h_data;

    entry_t                mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [2:0]            occupancy;
    logic [7:0]            b_res;
    logic [7:0]            a_res;
    entry_t                head;

    assign pop       = out_valid && out_ready;
    assign push      = p_valid;
    assign occupancy = {1'b0, count} + {2'b00, p_valid} - {2'b00, pop};
    // Reserve a slot for the pending entry, which is pushed unconditionally next edge.
    assign in_ready  = occupancy < 3'd2;
    assign accept    = in_valid && in_ready;
    assign rf_re     = accept && !in_use_imm;
    assign rf_raddr  = in_raddr;

    // Current write beats history; history covers a write at the issue edge the RAM read missed.
    always_comb begin
        b_res = rf_rdata;
        if (p_use_imm)
            b_res = p_imm;
        else if (wb_we && wb_addr == p_raddr)
            b_res = wb_data;
        else if (h_we && h_addr == p_raddr)
            b_res = h_data;
    end

    assign a_res = acc_we ? acc_wdata : acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_valid    <= 1'b0;
            p_op_sel   <= '0;
            p_a_sel    <= 1'b0;
            p_b_sel    <= '0;
            p_use_imm  <= 1'b0;
            p_imm      <= '0;
            p_raddr    <= '0;
            p_dest_acc <= 1'b0;
            h_we       <= 1'b0;
            h_addr     <= '0;
            h_data     <= '0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_op_sel   <= in_op_sel;
                p_a_sel    <= in_a_sel;
                p_b_sel    <= in_b_sel;
                p_use_imm  <= in_use_imm;
                p_imm      <= in_imm;
                p_raddr    <= in_raddr;
                p_dest_acc <= in_dest_acc;
            end
            h_we   <= wb_we;
            h_addr <= wb_addr;
            h_data <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++)
                mem[i] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{a: a_res, b: b_res, op_sel: p_op_sel, a_sel: p_a_sel,
                                 b_sel: p_b_sel, dest_acc: p_dest_acc, waddr: p_raddr};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head         = mem[rd_ptr];
    assign out_valid    = count != 2'd0;
    assign a            = head.a;
    assign b            = head.b;
    assign op_sel       = head.op_sel;
    assign a_sel        = head.a_sel;
    assign b_sel        = head.b_sel;
    assign out_dest_acc = head.dest_acc;
    assign out_waddr    = head.waddr;

endmodule
